// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
//
// Oversampling UART receiver with parity and stop-bit checking, line-break
// detection, and a single-entry valid/ready output holding register.
//
// Parameters
//   DATA_BITS  : data bits per frame (5..9)
//   OVERSAMPLE : sample_tick pulses per bit (even, 8..32)
//   PARITY     : 0 none, 1 even, 2 odd
//   STOP_BITS  : stop bits checked (1 or 2)
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   serial line (asynchronous, idle high)
//   sample_tick in   one-clk-wide oversample strobe
//   data_out    out  received word (first bit on the line is the LSB)
//   out_valid   out  data_out and the flags hold an unconsumed frame
//   out_ready   in   consumer accepts when out_valid & out_ready
//   parity_err  out  held frame has a parity mismatch (0 when PARITY=0)
//   frame_err   out  held frame had a stop bit sampled low
//   break_det   out  one-clk pulse on line-break detection
//   overrun     out  one-clk pulse when a completed frame is dropped
// ---------------------------------------------------------------------------
module uart_rx_framed #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_data,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);

  // Tick positions inside one bit: two early votes, then the deciding vote.
  localparam logic [TW-1:0] T_LO  = TW'(M - 1);
  localparam logic [TW-1:0] T_MID = TW'(M);
  localparam logic [TW-1:0] T_DEC = TW'(M + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Line synchronizer (resets to the idle-high level)
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic rxs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_data;
      rxs_q   <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------
  state_t               state_q,    state_d;
  logic [TW-1:0]        tick_q,     tick_d;
  logic [3:0]           bit_q,      bit_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 samp_lo_q,  samp_lo_d;
  logic                 samp_mid_q, samp_mid_d;
  logic                 par_q,      par_d;
  logic                 ferr_q,     ferr_d;
  // Stays 1 while every bit after the start bit has voted 0 (break candidate).
  logic                 zero_q,     zero_d;

  // Output holding register
  logic [DATA_BITS-1:0] data_out_q,   data_out_d;
  logic                 out_valid_q,  out_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 break_det_q,  break_det_d;
  logic                 overrun_q,    overrun_d;

  logic maj;
  logic tick_wrap;
  logic stop_ferr;
  logic stop_zero;
  logic commit;
  logic perr_calc;

  // 2-of-3 vote: the two stored samples plus the live sample at T_DEC.
  assign maj       = (samp_lo_q & samp_mid_q) | (samp_lo_q & rxs_q) | (samp_mid_q & rxs_q);
  assign tick_wrap = (tick_q == T_END);
  assign stop_ferr = ferr_q | ~maj;
  assign stop_zero = zero_q & ~maj;

  always_comb begin
    if (PARITY == 1) begin
      perr_calc = (^shift_q) ^ par_q;
    end else if (PARITY == 2) begin
      perr_calc = ~((^shift_q) ^ par_q);
    end else begin
      perr_calc = 1'b0;
    end
  end

  // Next-state logic. Everything except the synchronizer and the output
  // handshake only moves on sample_tick.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    samp_lo_d   = samp_lo_q;
    samp_mid_d  = samp_mid_q;
    par_d       = par_q;
    ferr_d      = ferr_q;
    zero_d      = zero_q;
    commit      = 1'b0;
    break_det_d = 1'b0;

    if (sample_tick) begin
      if (state_q != S_IDLE && state_q != S_BRK_WAIT) begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_q == T_LO)  samp_lo_d  = rxs_q;
        if (tick_q == T_MID) samp_mid_d = rxs_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
            par_d   = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end

        S_START: begin
          if (tick_q == T_DEC && maj) begin
            // Start bit did not hold low: treat as a glitch.
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (tick_wrap) begin
            state_d = S_DATA;
          end
        end

        S_DATA: begin
          if (tick_q == T_DEC) begin
            shift_d = {maj, shift_q[DATA_BITS-1:1]};
            if (maj) zero_d = 1'b0;
          end
          if (tick_wrap) begin
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (tick_q == T_DEC) begin
            par_d = maj;
            if (maj) zero_d = 1'b0;
          end
          if (tick_wrap) begin
            state_d = S_STOP;
            bit_d   = '0;
          end
        end

        S_STOP: begin
          if (tick_q == T_DEC) begin
            ferr_d = stop_ferr;
            zero_d = stop_zero;
            if (bit_q == LAST_STOP) begin
              // Decide at mid-bit of the last stop bit; no wait for its end.
              tick_d = '0;
              bit_d  = '0;
              if (stop_zero) begin
                state_d     = S_BRK_WAIT;
                break_det_d = 1'b1;
              end else begin
                state_d = S_IDLE;
                commit  = 1'b1;
              end
            end
          end else if (tick_wrap) begin
            bit_d = bit_q + 1'b1;
          end
        end

        S_BRK_WAIT: begin
          if (rxs_q) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register next state: a commit either loads the frame or, when
  // the previous frame is still unconsumed and not being accepted now,
  // is dropped with an overrun pulse.
  always_comb begin
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (commit) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_out_d   = shift_q;
        parity_err_d = perr_calc;
        frame_err_d  = stop_ferr;
        out_valid_d  = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      samp_lo_q    <= 1'b0;
      samp_mid_q   <= 1'b0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      zero_q       <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      samp_lo_q    <= samp_lo_d;
      samp_mid_q   <= samp_mid_d;
      par_q        <= par_d;
      ferr_q       <= ferr_d;
      zero_q       <= zero_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;

endmodule
